// File: rtl/optest_shr_seq_if.sv
// Start/done handshake bundle for the sequential shift unit.
// The master issues requests; the slave (the shift unit) reports busy/done and the result.
interface optest_shr_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMTW  = 4
);
    logic             start;
    logic [3:0]       mode;
    logic [WIDTH-1:0] a;
    logic [AMTW-1:0]  amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;

    modport master (
        output start, mode, a, amt,
        input  busy, done, y
    );

    modport slave (
        input  start, mode, a, amt,
        output busy, done, y
    );
endinterface

// File: rtl/optest_shr_seq.sv
// Multi-cycle shifter: one 1-bit shift per clock, right (logical/arithmetic) or left
// when a signed amount is negative; step count saturates at WIDTH.
module optest_shr_seq #(
    parameter int WIDTH = 8,
    parameter int AMTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    optest_shr_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] NOP_RESULT = WIDTH'(8'h42);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state_q;
    logic [WIDTH-1:0]        acc_q;
    logic [WIDTH-1:0]        y_q;
    logic [CW-1:0]           cnt_q;
    logic                    left_q;
    logic                    arith_q;
    logic                    busy_q;
    logic                    done_q;

    logic signed [AMTW-1:0]  amt_s;
    logic [AMTW-1:0]         ld_mag;
    logic [WIDTH-1:0]        ld_acc;
    logic                    ld_left;
    logic                    ld_arith;

    function automatic logic [CW-1:0] sat_count(input logic [AMTW-1:0] mag);
        if (int'(mag) >= WIDTH)
            return CW'(WIDTH);
        else
            return CW'(mag);
    endfunction

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                                input logic left,
                                                input logic arith);
        logic signed [WIDTH-1:0] vs;
        vs = v;
        if (left)
            return {v[WIDTH-2:0], 1'b0};
        else if (arith)
            return $unsigned(vs >>> 1);
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign amt_s = bus.amt;

    // Decode the request; -amt of the most negative value still yields its magnitude.
    always_comb begin
        ld_acc   = bus.a;
        ld_mag   = bus.amt;
        ld_left  = 1'b0;
        ld_arith = bus.mode[0];
        if (bus.mode[3:2] != 2'b00) begin
            ld_acc   = NOP_RESULT;
            ld_mag   = '0;
            ld_arith = 1'b0;
        end else if (bus.mode[1] && (amt_s < 0)) begin
            ld_left = 1'b1;
            ld_mag  = $unsigned(-amt_s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q   <= ld_acc;
                        cnt_q   <= sat_count(ld_mag);
                        left_q  <= ld_left;
                        arith_q <= ld_arith;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        acc_q <= shift1(acc_q, left_q, arith_q);
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        y_q     <= acc_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
endmodule

// File: tb/tb_optest_shr_seq.sv
// Bench for optest_shr_seq: timeline model checked every cycle plus directed
// vectors with hand-computed results and latencies.
module tb_optest_shr_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    optest_shr_seq_if #(.WIDTH(8), .AMTW(4)) bus ();

    optest_shr_seq #(.WIDTH(8), .AMTW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: result by whole-word arithmetic, completion time = accept edge + n + 1.
    int         cyc = 0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_y = 8'h00;
    logic [7:0] m_pend = 8'h00;
    int         done_at = 0;

    function automatic void model_op(input logic [3:0] mode, input logic [7:0] a,
                                     input logic [3:0] amt,
                                     output logic [7:0] res, output int n);
        int sh, mag, v;
        if (mode >= 4) begin
            res = 8'h42;
            n   = 0;
        end else begin
            sh  = mode[1] ? int'($signed(amt)) : int'(amt);
            mag = (sh < 0) ? -sh : sh;
            n   = (mag > 8) ? 8 : mag;
            if (sh < 0) begin
                res = 8'(int'(a) << mag);
            end else if (mode[0]) begin
                v   = int'($signed(a));
                res = 8'(v >>> mag);
            end else begin
                res = 8'(int'(a) >> mag);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_y    = 8'h00;
        end else begin
            logic [7:0] r;
            int         n;
            cyc++;
            m_done = 1'b0;
            if (m_busy) begin
                if (cyc == done_at) begin
                    m_y    = m_pend;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (bus.start === 1'b1) begin
                model_op(bus.mode, bus.a, bus.amt, r, n);
                m_pend  = r;
                done_at = cyc + n + 1;
                m_busy  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({bus.busy, bus.done, bus.y} !== {m_busy, m_done, m_y}) begin
            errors++;
            $display("FAIL cycle-compare t=%0t busy/done/y got %b/%b/%h want %b/%b/%h",
                     $time, bus.busy, bus.done, bus.y, m_busy, m_done, m_y);
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_done(input string name, input int k, output int lat, output logic found);
        found = 1'b0;
        lat   = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                found = 1'b1;
                lat   = cyc - k;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s-timeout no done within 20 cycles", name);
        end
    endtask

    task automatic do_op(input string name, input logic [3:0] mode, input logic [7:0] a,
                         input logic [3:0] amt, input logic [7:0] exp_y, input int exp_lat);
        int   k, lat;
        logic found;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = mode;
        bus.a     = a;
        bus.amt   = amt;
        @(posedge clk);
        #1;
        k = cyc;
        bus.start = 1'b0;
        check({name, "-busy"}, int'(bus.busy), 1);
        wait_done(name, k, lat, found);
        if (found) begin
            check({name, "-y"}, int'(bus.y), int'(exp_y));
            check({name, "-lat"}, lat, exp_lat);
        end
    endtask

    initial begin
        int   k, d1, d2, ndone, dedge, lat;
        logic found;
        bus.start = 1'b0;
        bus.mode  = 4'd0;
        bus.a     = 8'h00;
        bus.amt   = 4'h0;
        #1;
        check("reset-busy", int'(bus.busy), 0);
        check("reset-done", int'(bus.done), 0);
        check("reset-y", int'(bus.y), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op("m0-F0>>3",   4'd0, 8'hF0, 4'd3,  8'h1E, 4);
        do_op("m1-90>>>2",  4'd1, 8'h90, 4'd2,  8'hE4, 3);
        do_op("m1-80>>>15", 4'd1, 8'h80, 4'd15, 8'hFF, 9);
        do_op("m3-05<<2",   4'd3, 8'h05, 4'hE,  8'h14, 3);
        do_op("m2-81<<8",   4'd2, 8'h81, 4'h8,  8'h00, 9);
        do_op("m7-nop",     4'd7, 8'h33, 4'h5,  8'h42, 1);
        do_op("m0-amt0",    4'd0, 8'hA5, 4'd0,  8'hA5, 1);
        do_op("m2-81>>3",   4'd2, 8'h81, 4'd3,  8'h10, 4);
        do_op("m1-7F>>>9",  4'd1, 8'h7F, 4'd9,  8'h00, 9);
        do_op("m3-C3>>>7",  4'd3, 8'hC3, 4'h7,  8'hFF, 8);
        do_op("m0-FF>>8",   4'd0, 8'hFF, 4'd8,  8'h00, 9);
        do_op("m1-90>>>14", 4'd1, 8'h90, 4'hE,  8'hFF, 9);
        do_op("m15-nop",    4'd15, 8'h00, 4'h0, 8'h42, 1);

        // Second start during an operation must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 4'd0; bus.a = 8'hFF; bus.amt = 4'd5;
        @(posedge clk);
        #1;
        k = cyc;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.mode = 4'd7; bus.a = 8'h00; bus.amt = 4'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        dedge = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                ndone++;
                dedge = cyc - k;
                check("ignore-y", int'(bus.y), 8'h07);
            end
        end
        check("ignore-ndone", ndone, 1);
        check("ignore-lat", dedge, 6);

        // Held start: one operation per n+2 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 4'd0; bus.a = 8'hF0; bus.amt = 4'd3;
        @(posedge clk);
        #1;
        k = cyc;
        wait_done("b2b-1", k, lat, found);
        d1 = cyc;
        wait_done("b2b-2", k, lat, found);
        d2 = cyc;
        bus.start = 1'b0;
        check("b2b-period", d2 - d1, 5);
        check("b2b-y", int'(bus.y), 8'h1E);

        // Asynchronous reset mid-shift.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 4'd0; bus.a = 8'hFF; bus.amt = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst-busy", int'(bus.busy), 0);
        check("arst-done", int'(bus.done), 0);
        check("arst-y", int'(bus.y), 0);
        #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("arst-nodone", ndone, 0);
        do_op("post-rst", 4'd0, 8'hF0, 4'd3, 8'h1E, 4);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
